gate_ctrl: RTL

Measurement sequencer for the frequency meter. Receives the 32-bit gate period over the SPI configuration path (`reg_wr_*` from the command decoder), then runs back-to-back gate windows aligned to edges of the measured signal. It drives clear/enable/latch strobes into the counter datapath and defers result latching while an SPI data read is in progress, so the reader never sees torn values.

---
 rtl/gate_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/gate_ctrl.sv
// gate_ctrl: measurement sequencer for the frequency meter. Holds the gate
// period written byte-wise over SPI, runs back-to-back gate windows aligned
// to measured-signal edges, and strobes clear/enable/latch into the counter
// datapath. The latch is deferred while an SPI result read is active.
module gate_ctrl #(
    parameter int unsigned ARM_TMO = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       reg_wr_en_i,
    input  logic [1:0] reg_wr_addr_i,
    input  logic [7:0] reg_wr_data_i,
    input  logic       reg_rd_en_i,
    input  logic       sig_edge_i,
    output logic       gate_en_o,
    output logic       cnt_clr_o,
    output logic       cnt_latch_o,
    output logic       data_rdy_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_GATE,
        S_WAIT_END,
        S_LATCH
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(ARM_TMO - 1);

    state_t      state_q, state_d;
    logic [31:0] shd_q, shd_d;
    logic [31:0] per_q, per_d;
    logic [31:0] tmr_q, tmr_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        rd_en_q, rd_en_d;
    logic        gate_en_q, gate_en_d;
    logic        cnt_clr_q, cnt_clr_d;
    logic        cnt_latch_q, cnt_latch_d;
    logic        data_rdy_q, data_rdy_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;

    logic        restart;
    logic        rd_rise;
    logic        tmo_hit;

    assign rd_rise = reg_rd_en_i & ~rd_en_q;
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    // Byte-wise shadow of the gate period; the top byte commits and restarts.
    always_comb begin
        shd_d   = shd_q;
        per_d   = per_q;
        restart = 1'b0;
        if (reg_wr_en_i) begin
            case (reg_wr_addr_i)
                2'd0: shd_d[7:0]   = reg_wr_data_i;
                2'd1: shd_d[15:8]  = reg_wr_data_i;
                2'd2: shd_d[23:16] = reg_wr_data_i;
                default: begin
                    shd_d[31:24] = reg_wr_data_i;
                    per_d        = {reg_wr_data_i, shd_q[23:0]};
                    restart      = 1'b1;
                end
            endcase
        end
    end

    // Sequencer next state; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        tmo_cnt_d   = tmo_cnt_q;
        rd_en_d     = reg_rd_en_i;
        cnt_latch_d = 1'b0;
        timeout_d   = timeout_q;
        data_rdy_d  = data_rdy_q;

        case (state_q)
            S_IDLE: begin
                if (per_q != 32'd0) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                tmo_cnt_d = 32'd0;
                state_d   = S_ARM;
            end
            S_ARM: begin
                if (sig_edge_i) begin
                    tmr_d   = per_q - 32'd1;
                    state_d = S_GATE;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_CLEAR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_GATE: begin
                // An edge during the final GATE cycle is deliberately ignored.
                if (tmr_q == 32'd0) begin
                    tmo_cnt_d = 32'd0;
                    state_d   = S_WAIT_END;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            S_WAIT_END: begin
                if (sig_edge_i) begin
                    state_d = S_LATCH;
                end else if (tmo_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_CLEAR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_LATCH: begin
                // First LATCH cycle with the read idle issues the strobe; the
                // cycle carrying the strobe then moves on to CLEAR.
                if (cnt_latch_q) begin
                    state_d = S_CLEAR;
                end else if (!reg_rd_en_i) begin
                    cnt_latch_d = 1'b1;
                    timeout_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            state_d     = (per_d != 32'd0) ? S_CLEAR : S_IDLE;
            cnt_latch_d = 1'b0;
            timeout_d   = 1'b0;
        end

        if (cnt_latch_d) begin
            data_rdy_d = 1'b1;
        end else if (rd_rise) begin
            data_rdy_d = 1'b0;
        end
    end

    // Registered output decode from the next state.
    always_comb begin
        gate_en_d = (state_d == S_GATE) || (state_d == S_WAIT_END);
        cnt_clr_d = (state_d == S_CLEAR);
        busy_d    = (state_d != S_IDLE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            shd_q       <= 32'd0;
            per_q       <= 32'd0;
            tmr_q       <= 32'd0;
            tmo_cnt_q   <= 32'd0;
            rd_en_q     <= 1'b0;
            gate_en_q   <= 1'b0;
            cnt_clr_q   <= 1'b0;
            cnt_latch_q <= 1'b0;
            data_rdy_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shd_q       <= shd_d;
            per_q       <= per_d;
            tmr_q       <= tmr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rd_en_q     <= rd_en_d;
            gate_en_q   <= gate_en_d;
            cnt_clr_q   <= cnt_clr_d;
            cnt_latch_q <= cnt_latch_d;
            data_rdy_q  <= data_rdy_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gate_en_o   = gate_en_q;
    assign cnt_clr_o   = cnt_clr_q;
    assign cnt_latch_o = cnt_latch_q;
    assign data_rdy_o  = data_rdy_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;

endmodule
